nios_pio_in_sync: RTL and testbench

NIOS_PIO_IN_SYNC -- requirements
Module: nios_pio_in_sync

---
 rtl/nios_pio_in_sync.sv | 108 ++++++++++
 tb/tb_nios_pio_in_sync.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios_pio_in_sync.sv
// Avalon-MM PIO input port: synchronizes in_port, optional RW1C edge capture with masked level irq.
// Edge capture and irq exist only when NIOS_PIO_IN_EDGE_CAPTURE_EN is defined; otherwise data path only.
module nios_pio_in_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_sync;
  logic [31:0]           rd_next;
  logic                  wr_en;
  logic                  unused_bus;

  assign wr_en      = chipselect & ~write_n;
  assign unused_bus = ^{wr_en, writedata};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign data_sync = in_port;
    end else begin : g_sync
      logic [DATA_WIDTH-1:0] stage [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
        end else begin
          stage[0] <= in_port;
          for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
      end
      assign data_sync = stage[SYNC_STAGES-1];
    end
  endgenerate

`ifdef NIOS_PIO_IN_EDGE_CAPTURE_EN
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] data_prev;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic                  primed;
  logic [1:0]            warm_cnt;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = data_sync & ~data_prev;
      1:       edge_det = ~data_sync & data_prev;
      default: edge_det = data_sync ^ data_prev;
    endcase
  end

  assign clr_bits = (wr_en && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;

  // primed waits until the synchronizer has refilled from its reset zeros,
  // so the pin level present at reset release is never seen as an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      data_prev    <= '0;
      primed       <= 1'b0;
      warm_cnt     <= '0;
    end else begin
      data_prev <= data_sync;
      if (wr_en && address == 2'd2) irq_mask <= writedata[DATA_WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr_bits) | (primed ? edge_det : '0);
      if (!primed) begin
        if (warm_cnt == 2'(SYNC_STAGES)) primed <= 1'b1;
        else warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[DATA_WIDTH-1:0] = data_sync;
      2'd2:    rd_next[DATA_WIDTH-1:0] = irq_mask;
      2'd3:    rd_next[DATA_WIDTH-1:0] = edge_capture;
      default: rd_next = '0;
    endcase
  end
`else
  assign irq = 1'b0;

  always_comb begin
    rd_next = '0;
    if (address == 2'd0) rd_next[DATA_WIDTH-1:0] = data_sync;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_nios_pio_in_sync.sv
// Bench for nios_pio_in_sync: rising-edge instance plus an any-edge instance on a shared bus.
// Edge-capture sequences run only when NIOS_PIO_IN_EDGE_CAPTURE_EN is defined.
module tb_nios_pio_in_sync;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata, readdata_any;
  logic        irq, irq_any;

  nios_pio_in_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  nios_pio_in_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_any), .irq(irq_any)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0]  in_val;
    logic [1:0]  addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // One-cycle read on the rising-edge instance through the scoreboard queue.
  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    sb_t e;
    sb_q.push_back('{name, exp});
    address = a;
    tick(1);
    e = sb_q.pop_front();
    chk(e.name, readdata, e.exp);
  endtask

  initial begin
    sb_t e;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hA5;

    // Reset and data-path latency with the level held across release.
    tick(3);
    chk("rst_rd", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(2);
    chk("rd_2clk", readdata, 32'h0);
    tick(1);
    chk("rd_3clk", readdata, 32'hA5);
    tick(1);
    chk("rd_4clk", readdata, 32'hA5);
    rd("post_rst_cap", 2'd3, 32'h0);
    chk("post_rst_cap_any", readdata_any, 32'h0);

    vecs.push_back('{8'h5A, 2'd0, 32'h5A});
    vecs.push_back('{8'hFF, 2'd1, 32'h0});
    vecs.push_back('{8'h00, 2'd0, 32'h00});
    vecs.push_back('{8'h80, 2'd0, 32'h80});
    vecs.push_back('{8'h01, 2'd0, 32'h01});
    vecs.push_back('{8'hC3, 2'd0, 32'hC3});
`ifndef NIOS_PIO_IN_EDGE_CAPTURE_EN
    vecs.push_back('{8'hFF, 2'd2, 32'h0});
    vecs.push_back('{8'h3C, 2'd3, 32'h0});
`endif
    foreach (vecs[i]) begin
      in_port = vecs[i].in_val;
      address = vecs[i].addr;
      sb_q.push_back('{$sformatf("vec%0d", i), vecs[i].exp});
      tick(3);
      e = sb_q.pop_front();
      chk(e.name, readdata, e.exp);
      chk({e.name, "_any"}, readdata_any, e.exp);
    end

`ifdef NIOS_PIO_IN_EDGE_CAPTURE_EN
    in_port = 8'h00;
    tick(5);
    bus_write(2'd3, 32'hFF);
    rd("clr_all", 2'd3, 32'h0);
    bus_write(2'd2, 32'h08);
    rd("mask_rb", 2'd2, 32'h08);

    // Rising edge on bit 3: capture after 3 clocks, visible on readdata after 4.
    in_port = 8'h08;
    address = 2'd3;
    tick(2);
    chk("irq_early", {31'b0, irq}, 32'h0);
    tick(1);
    chk("irq_set", {31'b0, irq}, 32'h1);
    rd("cap_rd", 2'd3, 32'h08);
    bus_write(2'd3, 32'h08);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    rd("cap_clr", 2'd3, 32'h0);

    // Edge and clear-write on the same bit in the same cycle.
    in_port = 8'h00;
    tick(4);
    in_port = 8'h08;
    tick(2);
    bus_write(2'd3, 32'h08);
    chk("set_wins_irq", {31'b0, irq}, 32'h1);
    rd("set_wins", 2'd3, 32'h08);

    in_port = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h09;
    tick(3);
    rd("cap_09", 2'd3, 32'h09);
    bus_write(2'd3, 32'h01);
    rd("w1c_partial", 2'd3, 32'h08);

    bus_write(2'd2, 32'h0);
    chk("mask_off", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'hFFFFFF08);
    chk("mask_on", {31'b0, irq}, 32'h1);
    rd("mask_hi", 2'd2, 32'h08);
    bus_write(2'd0, 32'hFF);
    rd("wr_addr0", 2'd0, 32'h09);
    address   = 2'd2;
    writedata = 32'h0;
    write_n   = 1'b0;
    tick(1);
    write_n   = 1'b1;
    rd("cs_gate", 2'd2, 32'h08);

    // Mid-operation reset with an interrupt pending.
    reset_n = 1'b0;
    tick(1);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    chk("midrst_rd", readdata, 32'h0);
    reset_n = 1'b1;
    rd("midrst_cap", 2'd3, 32'h0);
    rd("midrst_mask", 2'd2, 32'h0);
    tick(5);
    rd("midrst_noedge", 2'd3, 32'h0);

    // Any-edge instance: pulse with mask off, then enable mask.
    in_port = 8'h00;
    tick(5);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h0);
    in_port = 8'h01;
    tick(4);
    in_port = 8'h00;
    tick(4);
    rd("pulse_rise", 2'd3, 32'h01);
    chk("pulse_any", readdata_any, 32'h01);
    chk("pulse_any_irq0", {31'b0, irq_any}, 32'h0);
    bus_write(2'd2, 32'h01);
    chk("any_irq", {31'b0, irq_any}, 32'h1);

    in_port = 8'h02;
    tick(4);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h00;
    tick(4);
    rd("fall_ignored", 2'd3, 32'h00);
    chk("fall_any", readdata_any, 32'h02);
`else
    bus_write(2'd2, 32'hFF);
    rd("mask_na", 2'd2, 32'h0);
    for (int i = 0; i < 8; i++) begin
      in_port = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick(1);
      chk($sformatf("irq_na%0d", i), {30'b0, irq_any, irq}, 32'h0);
    end
    bus_write(2'd3, 32'hFF);
    tick(3);
    rd("cap_na", 2'd3, 32'h0);
    chk("cap_na_any", readdata_any, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
